// File: rtl/stdp_pkg.sv
// Shared types and default constants for the STDP weight-update scheduler.
package stdp_pkg;

    localparam int W_WIDTH_DEF  = 8;
    localparam int DT_WIDTH_DEF = 4;
    localparam int WIN_DEF      = 15;
    localparam int W_INIT_DEF   = 128;
    localparam int A_PLUS_DEF   = 16;
    localparam int A_MINUS_DEF  = 12;

    typedef enum logic [1:0] {
        IDLE,
        PRE_WAIT,
        POST_WAIT,
        UPDATE
    } state_t;

endpackage

// File: rtl/stdp_scheduler_if.sv
// Spike inputs and weight/status outputs of one plastic synapse.
interface stdp_scheduler_if
    import stdp_pkg::*;
#(
    parameter int W_WIDTH  = W_WIDTH_DEF,
    parameter int DT_WIDTH = DT_WIDTH_DEF
);
    logic                learn_en;
    logic                pre_spike;
    logic                post_spike;
    logic [W_WIDTH-1:0]  weight;
    logic                update_w_flag;
    logic                ltp;
    logic [DT_WIDTH-1:0] time_diff;
    logic                busy;

    modport master (
        output learn_en, pre_spike, post_spike,
        input  weight, update_w_flag, ltp, time_diff, busy
    );

    modport slave (
        input  learn_en, pre_spike, post_spike,
        output weight, update_w_flag, ltp, time_diff, busy
    );
endinterface

// File: rtl/stdp_delta.sv
// Combinational STDP step: amplitude scaled down by the coarse spike interval,
// then added or subtracted with saturation to the weight range.
module stdp_delta
    import stdp_pkg::*;
#(
    parameter int W_WIDTH  = W_WIDTH_DEF,
    parameter int DT_WIDTH = DT_WIDTH_DEF,
    parameter int A_PLUS   = A_PLUS_DEF,
    parameter int A_MINUS  = A_MINUS_DEF
) (
    input  logic [W_WIDTH-1:0]  w,
    input  logic [DT_WIDTH-1:0] dt,
    input  logic                ltp,
    output logic [W_WIDTH-1:0]  w_new
);
    logic [DT_WIDTH-1:0] shift;
    logic [W_WIDTH-1:0]  amp;
    logic [W_WIDTH-1:0]  delta;
    logic [W_WIDTH:0]    sum;
    logic [W_WIDTH:0]    diff;

    // Only the two MSBs of dt select the decay: longer intervals, smaller steps.
    assign shift = dt >> (DT_WIDTH - 2);
    assign amp   = ltp ? W_WIDTH'(A_PLUS) : W_WIDTH'(A_MINUS);
    assign delta = amp >> shift;

    // The guard bit is the carry on add and the borrow on subtract.
    assign sum  = {1'b0, w} + {1'b0, delta};
    assign diff = {1'b0, w} - {1'b0, delta};

    always_comb begin
        if (ltp) w_new = sum[W_WIDTH]  ? '1 : sum[W_WIDTH-1:0];
        else     w_new = diff[W_WIDTH] ? '0 : diff[W_WIDTH-1:0];
    end
endmodule

// File: rtl/stdp_scheduler.sv
// Pairs pre/post spikes within a window and applies one saturating
// potentiation or depression step per pairing.
module stdp_scheduler
    import stdp_pkg::*;
#(
    parameter int W_WIDTH  = W_WIDTH_DEF,
    parameter int DT_WIDTH = DT_WIDTH_DEF,
    parameter int WIN      = WIN_DEF,
    parameter int W_INIT   = W_INIT_DEF,
    parameter int A_PLUS   = A_PLUS_DEF,
    parameter int A_MINUS  = A_MINUS_DEF
) (
    input logic              clk,
    input logic              rst,
    stdp_scheduler_if.slave  bus
);
    state_t              state, state_nxt;
    logic [DT_WIDTH-1:0] cnt, cnt_nxt;
    logic [DT_WIDTH-1:0] pend_dt, pend_dt_nxt;
    logic                pend_ltp, pend_ltp_nxt;
    logic                write_en;

    logic [W_WIDTH-1:0]  weight_q, weight_new;
    logic                flag_q, ltp_q;
    logic [DT_WIDTH-1:0] time_diff_q;

    stdp_delta #(
        .W_WIDTH (W_WIDTH),
        .DT_WIDTH(DT_WIDTH),
        .A_PLUS  (A_PLUS),
        .A_MINUS (A_MINUS)
    ) u_delta (
        .w    (weight_q),
        .dt   (pend_dt),
        .ltp  (pend_ltp),
        .w_new(weight_new)
    );

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_dt_nxt  = pend_dt;
        pend_ltp_nxt = pend_ltp;
        write_en     = 1'b0;

        if (!bus.learn_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.pre_spike ^ bus.post_spike) begin
                        state_nxt = bus.pre_spike ? PRE_WAIT : POST_WAIT;
                        cnt_nxt   = DT_WIDTH'(1);
                    end
                end
                PRE_WAIT: begin
                    if (bus.post_spike) begin
                        state_nxt    = UPDATE;
                        pend_dt_nxt  = cnt;
                        pend_ltp_nxt = 1'b1;
                        cnt_nxt      = '0;
                    end else if (bus.pre_spike) begin
                        cnt_nxt = DT_WIDTH'(1);
                    end else if (cnt == DT_WIDTH'(WIN)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + DT_WIDTH'(1);
                    end
                end
                POST_WAIT: begin
                    if (bus.pre_spike) begin
                        state_nxt    = UPDATE;
                        pend_dt_nxt  = cnt;
                        pend_ltp_nxt = 1'b0;
                        cnt_nxt      = '0;
                    end else if (bus.post_spike) begin
                        cnt_nxt = DT_WIDTH'(1);
                    end else if (cnt == DT_WIDTH'(WIN)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + DT_WIDTH'(1);
                    end
                end
                UPDATE: begin
                    write_en  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_dt     <= '0;
            pend_ltp    <= 1'b0;
            weight_q    <= W_WIDTH'(W_INIT);
            flag_q      <= 1'b0;
            ltp_q       <= 1'b0;
            time_diff_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_dt  <= pend_dt_nxt;
            pend_ltp <= pend_ltp_nxt;
            flag_q   <= write_en;
            if (write_en) begin
                weight_q    <= weight_new;
                ltp_q       <= pend_ltp;
                time_diff_q <= pend_dt;
            end
        end
    end

    assign bus.weight        = weight_q;
    assign bus.update_w_flag = flag_q;
    assign bus.ltp           = ltp_q;
    assign bus.time_diff     = time_diff_q;
    assign bus.busy          = (state != IDLE);
endmodule

// File: doc/stdp_scheduler.md
STDP_SCHEDULER -- requirements
Module: stdp_scheduler

Interface
REQ-001 Parameter W_WIDTH, default 8: synaptic weight width, unsigned.
REQ-002 Parameter DT_WIDTH, default 4: spike-timing counter width.
REQ-003 Parameter WIN, default 15: pairing window in cycles, 1..2^DT_WIDTH-1.
REQ-004 Parameter W_INIT, default 128: weight reset value.
REQ-005 Parameters A_PLUS, A_MINUS, defaults 16, 12: LTP/LTD base amplitudes, W_WIDTH bits.
REQ-006 Port clk  input  1: single clock; all logic on its rising edge.
REQ-007 Port rst  input  1: reset, synchronous, active-high.
REQ-008 Port learn_en  input  1: 1 = learning enabled.
REQ-009 Port pre_spike  input  1: one-cycle spike pulse from the presynaptic lif.
REQ-010 Port post_spike  input  1: one-cycle spike pulse from the postsynaptic lif.
REQ-011 Port weight  output  W_WIDTH: current synaptic weight, registered.
REQ-012 Port update_w_flag  output  1: one-cycle pulse, weight changed this cycle.
REQ-013 Port ltp  output  1: polarity of last update, 1 = potentiation; registered.
REQ-014 Port time_diff  output  DT_WIDTH: spike interval of last update; registered.
REQ-015 Port busy  output  1: high whenever the FSM is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, PRE_WAIT, POST_WAIT, UPDATE.
REQ-017 IDLE: pre only -> PRE_WAIT with cnt=1; post only -> POST_WAIT with cnt=1; both or neither -> stay IDLE, no update.
REQ-018 PRE_WAIT: post -> latch dt=cnt, ltp=1, go UPDATE (a coincident pre is ignored); pre only -> cnt=1 (restart on the latest pre); cnt==WIN -> IDLE, no update; otherwise cnt+1.
REQ-019 POST_WAIT: mirror of PRE_WAIT with roles swapped; a pre terminates pairing with ltp=0.
REQ-020 UPDATE SHALL last exactly one cycle, ignore spikes, and return to IDLE.
REQ-021 Delta magnitude SHALL be amp >> dt[DT_WIDTH-1:DT_WIDTH-2], with amp = A_PLUS if ltp else A_MINUS.
REQ-022 On the edge leaving UPDATE, weight SHALL become min(2^W_WIDTH-1, w+delta) for LTP or max(0, w-delta) for LTD, computed without overflow (one guard bit).
REQ-023 update_w_flag SHALL be high for exactly the one cycle after that edge; time_diff and ltp SHALL update on the same edge and hold until the next update.
REQ-024 learn_en low SHALL force the FSM to IDLE on the next edge, freeze weight, and suppress the flag; an in-flight UPDATE is abandoned.
REQ-025 The latency from the pairing spike to the weight change SHALL be 2 edges (capture -> UPDATE -> write).

Reset
REQ-026 rst high at an edge SHALL set state=IDLE, cnt=0, weight=W_INIT, update_w_flag=0, ltp=0, time_diff=0, busy=0, taking priority over all inputs, including mid-pairing and in UPDATE.

Structure
REQ-027 Package stdp_pkg SHALL hold the state enum typedef and the default parameter constants (W_WIDTH, DT_WIDTH, WIN, W_INIT, A_PLUS, A_MINUS).
REQ-028 The delta and saturation arithmetic SHALL live in a combinational sub-module stdp_delta (inputs w, dt, ltp; output new weight).
REQ-029 Estimated size: 150-300 lines RTL total.

Verification (defaults, W_INIT=128)
REQ-030 pre at cycle 0, post at cycle 3 -> time_diff=3, ltp=1, weight 128->144, flag high exactly 1 cycle.
REQ-031 post at cycle 0, pre at cycle 9 -> time_diff=9, ltp=0, delta 12>>2=3, weight 125.
REQ-032 pre only, no post for 20 cycles -> busy drops after cycle 15, flag never pulses, weight stays 128.
REQ-033 weight preloaded to 250 via repeated LTP, then pre/post with dt=1 -> weight saturates at 255; LTD pairings driving toward 0 stop at 0.
REQ-034 pre and post in the same cycle in IDLE -> no state change and no flag; pre, then pre again at cycle 5, then post at cycle 7 -> time_diff=2.
REQ-035 rst asserted in PRE_WAIT at cnt=4 -> next cycle all outputs at reset values and weight=128; learn_en=0 during a pairing -> weight unchanged.
